// File: rtl/fifo_read_arb_pkg.sv
// Shared types and helpers for the FIFO read-port arbiter.
// Holds the FSM state type plus the burst-length width and saturation rules.
package fifo_read_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  function automatic int burst_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A zero length still reads one word; anything past max_burst is clipped.
  function automatic logic [31:0] sat_len(input logic [31:0] len, input int max_burst);
    if (len == 32'd0) begin
      return 32'd1;
    end
    if (len > 32'(max_burst)) begin
      return 32'(max_burst);
    end
    return len;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority select: first set request at or above i_ptr,
// wrapping modulo N. Produces a one-hot grant and its index.
module rr_arbiter
  import fifo_read_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_any,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx
);

  logic [N-1:0]     w_rot;
  logic             w_found;
  logic [IDX_W-1:0] w_off;
  logic [IDX_W:0]   w_sum;
  logic [IDX_W:0]   w_idx;

  // Rotate so that bit 0 of w_rot is the request at i_ptr.
  assign w_rot = N'({i_req, i_req} >> i_ptr);

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        w_off   = IDX_W'(i);
      end
    end
  end

  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
  assign w_idx = (w_sum >= (IDX_W+1)'(N)) ? (w_sum - (IDX_W+1)'(N)) : w_sum;

  assign o_any = w_found;
  assign o_idx = w_idx[IDX_W-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_gnt
      assign o_gnt[gi] = w_found && (w_idx == (IDX_W+1)'(gi));
    end
  endgenerate

endmodule

// File: rtl/fifo_read_arbiter.sv
// Round-robin burst arbiter sharing one FIFO read port among NUM_REQ consumers.
// Define FIFO_READ_ARB_TIMEOUT_EN to abort bursts stalled on empty for TIMEOUT cycles.
module fifo_read_arbiter
  import fifo_read_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8,
  parameter int TIMEOUT    = 16,
  localparam int BURST_W   = burst_w(MAX_BURST)
) (
  input  logic                       rclk,
  input  logic                       rrst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*BURST_W-1:0] req_len,
  input  logic                       empty,
  input  logic [DATA_WIDTH-1:0]      rdata,
  output logic                       r_en,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [NUM_REQ-1:0]         out_valid,
  output logic [NUM_REQ-1:0]         burst_done,
  output logic                       burst_abort,
  output logic                       busy
);

  localparam int IDX_W = idx_w(NUM_REQ);

  arb_state_e         r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [IDX_W-1:0]   r_gnt_idx;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [BURST_W-1:0] r_remaining;
  logic               r_rd_pend;

  logic               w_arb_any;
  logic [NUM_REQ-1:0] w_arb_gnt;
  logic [IDX_W-1:0]   w_arb_idx;
  logic [BURST_W-1:0] w_len [NUM_REQ];
  logic [BURST_W-1:0] w_len_sat;
  logic               w_rd;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_len
      assign w_len[gi] = req_len[gi*BURST_W +: BURST_W];
    end
  endgenerate

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .i_req (req),
    .i_ptr (r_rr_ptr),
    .o_any (w_arb_any),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx)
  );

  assign w_len_sat = BURST_W'(sat_len(32'(w_len[w_arb_idx]), MAX_BURST));

  // empty is already registered upstream, so gating r_en on it directly is safe.
  assign w_rd = !rrst && (r_state == BURST) && !empty && (r_remaining != '0);

`ifdef FIFO_READ_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);

  logic [STALL_W-1:0] r_stall;
  logic               r_abort;
  logic               w_timeout;

  // r_stall counts cycles since the last accepted read (that cycle counts as 1),
  // so leaving BURST at TIMEOUT-1 lands the abort pulse TIMEOUT cycles after it.
  assign w_timeout = (r_state == BURST) && empty && (r_stall == STALL_W'(TIMEOUT - 1));

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_stall <= '0;
      r_abort <= 1'b0;
    end else begin
      if (r_state == IDLE || w_rd) begin
        r_stall <= STALL_W'(1);
      end else if (r_state == BURST && empty && !w_timeout) begin
        r_stall <= r_stall + 1'b1;
      end
      if (w_timeout) begin
        r_abort <= 1'b1;
      end else if (r_state == DRAIN) begin
        r_abort <= 1'b0;
      end
    end
  end

  assign burst_abort = (r_state == DRAIN) && r_abort;
`else
  assign burst_abort = 1'b0;
`endif

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_rr_ptr    <= '0;
      r_remaining <= '0;
      r_rd_pend   <= 1'b0;
    end else begin
      r_rd_pend <= w_rd;
      case (r_state)
        IDLE: begin
          if (w_arb_any) begin
            r_gnt       <= w_arb_gnt;
            r_gnt_idx   <= w_arb_idx;
            r_remaining <= w_len_sat;
            r_state     <= BURST;
          end
        end
        BURST: begin
          if (w_rd) begin
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == BURST_W'(1)) begin
              r_state <= DRAIN;
            end
          end
`ifdef FIFO_READ_ARB_TIMEOUT_EN
          if (w_timeout) begin
            r_remaining <= '0;
            r_state     <= DRAIN;
          end
`endif
        end
        DRAIN: begin
          r_gnt    <= '0;
          r_rr_ptr <= (r_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;
          r_state  <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign r_en       = w_rd;
  assign gnt        = r_gnt;
  assign busy       = (r_state != IDLE);
  assign out_valid  = {NUM_REQ{r_rd_pend}} & r_gnt;
  assign out_data   = r_rd_pend ? rdata : '0;
  assign burst_done = (r_state == DRAIN) ? r_gnt : '0;

endmodule
